// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NREQ byte requesters, with start-ack timeout/retry.
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module uart_tx_arbiter #(
  parameter int NREQ        = 2,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic [NREQ-1:0]        grant,
  output logic                   busy
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [7:0]          cnt_q, cnt_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [NREQ-1:0]     win_onehot;

  // Scan in reverse so the last hit is the first requester in priority order.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
`else
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(idx);
      end
    end
`endif
    win_onehot = NREQ'(1) << win_idx;
  end

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready    = win_onehot;
          tx_data_d    = req_data[int'(win_idx)*DATA_W +: DATA_W];
          grant_d      = win_onehot;
          last_grant_d = win_idx;
          state_d      = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // Compare before incrementing: ACK_TIMEOUT wait cycles, re-pulse ACK_TIMEOUT+1 after the first.
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
          state_d = START;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    tx_start_d = (state_d == START);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NREQ - 1);
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);

endmodule
